// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: 2-stage token/data decode plus word-alignment FSM
// that requests deserializer bitslips until a run of control tokens is seen.
module tmds_channel_decoder #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_SETTLE    = 16,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds_word,
  output logic       bitslip,
  output logic       aligned,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] c,
  output logic [3:0] slip_count
);

  // state     | meaning
  // ST_SEARCH | counting control-token runs, timing out toward a bitslip
  // ST_SLIP   | one-cycle bitslip request
  // ST_SETTLE | ignore input while the deserializer boundary moves
  // ST_LOCKED | word boundary found; watch for loss of control tokens
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int RUN_W  = (CTRL_RUN > 1)       ? $clog2(CTRL_RUN)       : 1;
  localparam int TMO_W  = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int SET_W  = (SLIP_SETTLE > 1)    ? $clog2(SLIP_SETTLE)    : 1;
  localparam int IDLE_W = (LOCK_TIMEOUT > 1)   ? $clog2(LOCK_TIMEOUT)   : 1;

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SLIP_SETTLE - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOCK_TIMEOUT - 1);

  logic [9:0]        word_d, word_q;
  logic              de_d, de_q;
  logic [7:0]        data_d, data_q;
  logic [1:0]        c_d, c_q;
  logic              is_ctrl;
  logic [1:0]        tok_c;
  logic [7:0]        dmask;
  logic [7:0]        dec;

  state_t            state_d, state_q;
  logic [RUN_W-1:0]  run_d, run_q;
  logic [TMO_W-1:0]  tmo_d, tmo_q;
  logic [SET_W-1:0]  settle_d, settle_q;
  logic [IDLE_W-1:0] idle_d, idle_q;
  logic [3:0]        slip_cnt_d, slip_cnt_q;
  logic              aligned_d, aligned_q;

  // Decode of the registered word feeds both the output stage and the FSM.
  always_comb begin
    word_d  = tmds_word;
    is_ctrl = 1'b1;
    tok_c   = 2'b00;
    case (word_q)
      10'h354: tok_c = 2'b00;
      10'h0AB: tok_c = 2'b01;
      10'h154: tok_c = 2'b10;
      10'h2AB: tok_c = 2'b11;
      default: is_ctrl = 1'b0;
    endcase
    dmask  = word_q[7:0] ^ {8{word_q[9]}};
    dec    = 8'h00;
    dec[0] = dmask[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = word_q[8] ? (dmask[i] ^ dmask[i-1]) : ~(dmask[i] ^ dmask[i-1]);
    end
    de_d   = ~is_ctrl;
    data_d = is_ctrl ? 8'h00 : dec;
    c_d    = is_ctrl ? tok_c : c_q;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      de_q   <= 1'b0;
      data_q <= 8'h00;
      c_q    <= 2'b00;
    end else begin
      word_q <= word_d;
      de_q   <= de_d;
      data_q <= data_d;
      c_q    <= c_d;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) state_q <= ST_SEARCH;
    else       state_q <= state_d;
  end

  // Lock is checked before timeout so a run completing on the timeout cycle wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (is_ctrl && (run_q == RUN_LAST)) state_d = ST_LOCKED;
        else if (tmo_q == TMO_LAST)         state_d = ST_SLIP;
      end
      ST_SLIP:   state_d = ST_SETTLE;
      ST_SETTLE: if (settle_q == SET_LAST) state_d = ST_SEARCH;
      ST_LOCKED: if (!is_ctrl && (idle_q == IDLE_LAST)) state_d = ST_SEARCH;
      default:   state_d = ST_SEARCH;
    endcase
  end

  // Counters are zero outside the state that owns them and saturate at all-ones.
  always_comb begin
    run_d      = '0;
    tmo_d      = '0;
    settle_d   = '0;
    idle_d     = '0;
    slip_cnt_d = slip_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (state_d == ST_SEARCH) begin
          if (is_ctrl) run_d = (&run_q) ? run_q : run_q + RUN_W'(1);
          tmo_d = (&tmo_q) ? tmo_q : tmo_q + TMO_W'(1);
        end else if (state_d == ST_LOCKED) begin
          slip_cnt_d = 4'd0;
        end
      end
      ST_SLIP: slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
      ST_SETTLE: begin
        if (state_d == ST_SETTLE) settle_d = (&settle_q) ? settle_q : settle_q + SET_W'(1);
      end
      ST_LOCKED: begin
        if ((state_d == ST_LOCKED) && !is_ctrl) idle_d = (&idle_q) ? idle_q : idle_q + IDLE_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      run_q      <= '0;
      tmo_q      <= '0;
      settle_q   <= '0;
      idle_q     <= '0;
      slip_cnt_q <= 4'd0;
      aligned_q  <= 1'b0;
    end else begin
      run_q      <= run_d;
      tmo_q      <= tmo_d;
      settle_q   <= settle_d;
      idle_q     <= idle_d;
      slip_cnt_q <= slip_cnt_d;
      aligned_q  <= aligned_d;
    end
  end

  // bitslip decodes straight from state so an async reset truncates the pulse.
  always_comb begin
    bitslip   = (state_q == ST_SLIP);
    aligned_d = (state_d == ST_LOCKED);
  end

  assign aligned    = aligned_q;
  assign de         = de_q;
  assign data       = data_q;
  assign c          = c_q;
  assign slip_count = slip_cnt_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboarded bench for tmds_channel_decoder: reference decode model plus
// directed alignment scenarios (lock, slip cadence, lock loss, mid-slip reset).
module tb_tmds_channel_decoder;

  localparam int CTRL_RUN = 8;
  localparam int ST       = 2048;
  localparam int SS       = 16;
  localparam int LT       = 4096;
  localparam int PERIOD   = ST + SS + 1;

  logic       clk_pixel = 1'b0;
  logic       reset     = 1'b1;
  logic [9:0] tmds_word = 10'h000;
  logic       bitslip, aligned, de;
  logic [7:0] data;
  logic [1:0] c;
  logic [3:0] slip_count;

  tmds_channel_decoder #(
    .CTRL_RUN(CTRL_RUN), .SEARCH_TIMEOUT(ST), .SLIP_SETTLE(SS), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk_pixel(clk_pixel), .reset(reset), .tmds_word(tmds_word),
    .bitslip(bitslip), .aligned(aligned), .de(de), .data(data), .c(c),
    .slip_count(slip_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       de;
    logic [7:0] data;
    logic [1:0] c;
    logic       chk_al;
    logic       al;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] m_last_c = 2'b00;
  logic       m_locked = 1'b0;
  logic       m_chk_al = 1'b0;
  int         m_nc     = 0;
  int         bs_log[$];
  int         sc_log[$];
  int         rel_cyc  = 0;

  function automatic logic is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [1:0] tok_c(input logic [9:0] w);
    case (w)
      10'h0AB: return 2'b01;
      10'h154: return 2'b10;
      10'h2AB: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] d, q;
    d    = w[7:0] ^ {8{w[9]}};
    q    = 8'h00;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = d[i] ^ d[i-1] ^ ~w[8];
    return q;
  endfunction

  function automatic logic [9:0] rotr(input logic [9:0] w, input int r);
    logic [19:0] x;
    x = {w, w};
    return x[r +: 10];
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (is_tok(w));
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, got, exp);
    end
  endtask

  // Model: token table, TMDS decode rule, and consecutive-non-token lock-loss count.
  task automatic apply(input logic [9:0] w);
    exp_t e;
    tmds_word = w;
    e.due = cyc + 2;
    if (is_tok(w)) begin
      m_last_c = tok_c(w);
      e.de     = 1'b0;
      e.data   = 8'h00;
    end else begin
      e.de   = 1'b1;
      e.data = ref_decode(w);
    end
    e.c = m_last_c;
    if (m_locked) begin
      if (is_tok(w)) m_nc = 0;
      else           m_nc++;
      if (m_nc >= LT) m_locked = 1'b0;
    end
    e.chk_al = m_chk_al;
    e.al     = m_locked;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [9:0] w);
    @(negedge clk_pixel);
    apply(w);
  endtask

  task automatic model_clear();
    sb.delete();
    m_last_c = 2'b00;
    m_locked = 1'b0;
    m_nc     = 0;
    m_chk_al = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bitslip"}, bitslip, 1'b0);
    check({tag, "_aligned"}, aligned, 1'b0);
    check({tag, "_de"}, de, 1'b0);
    check({tag, "_data"}, data, 8'h00);
    check({tag, "_c"}, c, 2'b00);
    check({tag, "_slip_count"}, slip_count, 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_pixel);
    reset     = 1'b1;
    tmds_word = 10'h000;
    model_clear();
    repeat (2) @(negedge clk_pixel);
    check_reset_vals("rst");
    reset   = 1'b0;
    rel_cyc = cyc;
    bs_log.delete();
    sc_log.delete();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_pixel);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due == cyc) begin
          n_vec++;
          if (de !== e.de || data !== e.data || c !== e.c || (e.chk_al && aligned !== e.al)) begin
            n_err++;
            $display("FAIL dpath @cyc %0d: got de=%b data=%h c=%b aligned=%b, want de=%b data=%h c=%b aligned=%b (checked %b)",
                     cyc, de, data, c, aligned, e.de, e.data, e.c, e.al, e.chk_al);
          end
        end
      end
    end
  end

  initial begin : slip_logger
    logic bs_prev;
    bs_prev = 1'b0;
    forever begin
      @(negedge clk_pixel);
      if (bs_prev) sc_log.push_back(int'(slip_count));
      if (bitslip) bs_log.push_back(cyc);
      bs_prev = bitslip;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [9:0] toks [4];
    logic       hit, found;
    int         rot, pre_sc, lock_cyc;
    toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    do_reset();

    // Continuous 0x354: lock exactly CTRL_RUN cycles after the first token is registered.
    for (int j = 0; j < 14; j++) begin
      @(negedge clk_pixel);
      check("aligned_run", aligned, (j >= CTRL_RUN + 1));
      apply(10'h354);
    end
    check("no_slip_on_lock", bs_log.size(), 0);
    m_locked = 1'b1;
    m_nc     = 0;
    m_chk_al = 1'b1;

    drive(10'h100);
    drive(10'h2FF);
    drive(10'h2AB);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) drive(toks[$urandom_range(0, 3)]);
      else                           drive(rand_data());
    end

    // Data-only while locked, one 0x0AB at position 4000 restarts the idle count.
    for (int i = 1; i <= 8200; i++) drive((i == 4000) ? 10'h0AB : rand_data());
    repeat (3) @(negedge clk_pixel);
    check("aligned_dropped", aligned, 1'b0);

    // Random data only: periodic slips, slip_count 1..9,0,1.
    do_reset();
    m_chk_al = 1'b1;
    for (int i = 0; i < 23000; i++) drive(rand_data());
    check("slip_pulses", bs_log.size(), 11);
    if (bs_log.size() > 0) check("first_slip", bs_log[0] - rel_cyc, ST);
    for (int k = 1; k < bs_log.size(); k++) check("slip_gap", bs_log[k] - bs_log[k-1], PERIOD);
    for (int k = 0; k < sc_log.size(); k++) check("slip_count_seq", sc_log[k], (k + 1) % 10);

    // Reset landing on a bitslip cycle.
    hit = 1'b0;
    for (int j = 0; j < 2200 && !hit; j++) begin
      @(negedge clk_pixel);
      if (bitslip) hit = 1'b1;
      else         apply(rand_data());
    end
    check("slip_seen", hit, 1'b1);
    check("slip_count_pre_rst", slip_count, 4'd1);
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    check_reset_vals("rst_mid");
    repeat (2) @(negedge clk_pixel);
    reset   = 1'b0;
    rel_cyc = cyc;
    bs_log.delete();
    sc_log.delete();

    // 0x354 rotated by 3; deserializer model moves one bit per bitslip.
    rot      = 3;
    found    = 1'b0;
    pre_sc   = 0;
    lock_cyc = 0;
    for (int j = 0; j < 3 * PERIOD + 200 && !found; j++) begin
      @(negedge clk_pixel);
      if (aligned) begin
        found    = 1'b1;
        lock_cyc = cyc;
      end else begin
        pre_sc = int'(slip_count);
        if (bitslip) rot = (rot + 9) % 10;
        apply(rotr(10'h354, rot));
      end
    end
    check("rot_locked", found, 1'b1);
    check("rot_slip_pulses", bs_log.size(), 3);
    check("rot_prelock_count", pre_sc, 3);
    check("rot_postlock_count", slip_count, 4'd0);
    if (bs_log.size() > 0) check("rot_first_slip", bs_log[0] - rel_cyc, ST);
    for (int k = 1; k < bs_log.size(); k++) check("rot_slip_gap", bs_log[k] - bs_log[k-1], PERIOD);
    for (int k = 0; k < sc_log.size() && k < 3; k++) check("rot_slip_count", sc_log[k], k + 1);
    if (bs_log.size() == 3) check("rot_lock_time", lock_cyc - bs_log[2], SS + 1 + CTRL_RUN);

    repeat (3) @(negedge clk_pixel);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tmds_channel_decoder.md
TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 Parameter CTRL_RUN, default 8: consecutive control tokens required to declare word lock.
REQ-002 Parameter SEARCH_TIMEOUT, default 2048: clk_pixel cycles without a control-token run before a bitslip is requested.
REQ-003 Parameter SLIP_SETTLE, default 16: cycles ignored after each bitslip pulse.
REQ-004 Parameter LOCK_TIMEOUT, default 4096: cycles without any control token, while locked, before lock is dropped.
REQ-005 clk_pixel  in  1  pixel clock; sole clock; all state on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 tmds_word  in  10  raw parallel word from the 1:10 deserializer, one per cycle, bit 0 first on the wire.
REQ-008 bitslip  out  1  one-cycle pulse; the deserializer rotates its word boundary by one bit per pulse.
REQ-009 aligned  out  1  high while in LOCKED.
REQ-010 de  out  1  1 = video data word; 0 = control token or invalid word.
REQ-011 data  out  8  decoded video byte; 0x00 when de=0.
REQ-012 c  out  2  {c1,c0} of the most recent control token; holds its value while de=1.
REQ-013 slip_count  out  4  number of bitslips issued since the last lock, mod 10.

Function
REQ-014 Control tokens are 10'h354->c=00, 10'h0AB->c=01, 10'h154->c=10, 10'h2AB->c=11; any other word is a data word.
REQ-015 Data decode: d = tmds_word[9] ? ~tmds_word[7:0] : tmds_word[7:0]; data[0]=d[0]; for i=1..7, data[i] = tmds_word[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-016 Datapath latency is exactly 2 cycles: tmds_word is registered at edge k and de/data/c are registered at edge k+1. Decode runs regardless of FSM state.
REQ-017 FSM states: SEARCH, SLIP, SETTLE, LOCKED.
REQ-018 SEARCH: run counter counts consecutive control tokens and clears on any data word; timeout counter increments every cycle.
REQ-019 SEARCH -> LOCKED when the run counter reaches CTRL_RUN; the timeout counter and slip_count clear.
REQ-020 SEARCH -> SLIP when the timeout counter reaches SEARCH_TIMEOUT-1 without a lock. If the lock and timeout conditions occur in the same cycle, lock wins.
REQ-021 SLIP: bitslip=1 for exactly one cycle; slip_count increments and wraps 9->0; next state is SETTLE.
REQ-022 SETTLE: waits SLIP_SETTLE cycles with counters held at 0, then -> SEARCH. Tokens seen during SETTLE do not count.
REQ-023 LOCKED: the idle counter clears on every control token and increments otherwise. LOCKED -> SEARCH when it reaches LOCK_TIMEOUT-1; aligned falls on that same edge and the counters clear.
REQ-024 bitslip is never asserted outside SLIP; pulses are separated by at least SLIP_SETTLE+1 cycles.
REQ-025 Counters are sized by $clog2 of their parameter and saturate; they never wrap within a state.
REQ-026 aligned is a registered output: it rises on the edge that enters LOCKED.

Reset
REQ-027 While reset=1: state=SEARCH; all counters 0; bitslip=0, aligned=0, de=0, data=0x00, c=2'b00, slip_count=0; pipeline registers cleared.
REQ-028 Reset asserted mid-operation (including during SLIP) takes effect immediately and truncates any bitslip pulse. After release, operation restarts from SEARCH on the first clock edge.

Verification
REQ-029 Reset, then drive 10'h354 continuously -> aligned=1 exactly CTRL_RUN cycles after the first token is registered; de=0, c=00; bitslip never pulses.
REQ-030 Locked, then drive 10'h100 -> 2 cycles later de=1, data=0x00. Then drive 10'h2FF -> 2 cycles later data=0xFE. Then drive 10'h2AB -> de=0, data=0x00, c=11.
REQ-031 After reset, drive a stream of 10'h354 rotated by 3 bits; the model un-rotates by one bit per bitslip -> exactly 3 bitslip pulses, each followed by a SETTLE of 16 cycles; then aligned=1 with slip_count=0; a pre-lock probe reads 3.
REQ-032 Drive random data words only -> bitslip pulses every SEARCH_TIMEOUT+SLIP_SETTLE+1 cycles; slip_count sequence 1..9,0,1; aligned stays 0.
REQ-033 Locked, then drive only data words for 4096 cycles -> aligned drops on cycle LOCK_TIMEOUT; a single 10'h0AB at cycle 4000 resets the idle count and keeps lock.
REQ-034 Assert reset on the cycle bitslip=1 -> bitslip=0 immediately; all outputs read their reset values; slip_count=0.
